// File: rtl/rv32i_decode_queue.sv
// rv32i_decode_queue
//   Small instruction queue between fetch and execute. Each entry holds a
//   32-bit RV32I instruction word and its PC tag. The head entry is decoded
//   combinationally into register/function fields, a format code and the
//   sign-extended immediate. All decoded outputs read as zero while the queue
//   is empty.
//
// Parameters
//   DEPTH  number of entries (power of two, 2..16)
//   PC_W   width of the PC tag
//
// Ports
//   clk, rst_n            single clock; synchronous active-low reset
//   flush                 drop every queued entry (reset has priority)
//   in_valid/in_ready     fetch-side push handshake, with in_instr and in_pc
//   out_valid/out_ready   execute-side pop handshake
//   out_pc, opcode, rd, funct3, rs1, rs2, funct7   fields of the head entry
//   imm, fmt              immediate and format code
//                         (R=0 I=1 S=2 B=3 U=4 J=5 unknown=7)
//   count                 current occupancy
//   illegal               only when RV32I_DECQ_ILLEGAL_EN is defined: the head
//                         entry is not a recognisable RV32I encoding
module rv32i_decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [PC_W-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [6:0]             opcode,
  output logic [4:0]             rd,
  output logic [2:0]             funct3,
  output logic [4:0]             rs1,
  output logic [4:0]             rs2,
  output logic [6:0]             funct7,
  output logic [31:0]            imm,
  output logic [2:0]             fmt,
  output logic [$clog2(DEPTH):0] count
`ifdef RV32I_DECQ_ILLEGAL_EN
  ,
  output logic                   illegal
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]     instr_mem [DEPTH];
  logic [PC_W-1:0] pc_mem    [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic [31:0]     head;
  logic [2:0]      fmt_raw;
  logic [31:0]     imm_raw;

  // A full queue refuses a push even if the head leaves in the same cycle,
  // so in_ready depends only on registered state.
  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Pointers and occupancy. DEPTH is a power of two, so the AW-bit pointers
  // wrap on their own.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset. A flush or reset only rewinds the pointers, so
  // stale words stay in place but are never presented.
  always_ff @(posedge clk) begin
    if (push && rst_n && !flush) begin
      instr_mem[wr_ptr] <= in_instr;
      pc_mem[wr_ptr]    <= in_pc;
    end
  end

  assign head = instr_mem[rd_ptr];

  // Format classification from the major opcode.
  always_comb begin
    fmt_raw = 3'd7;
    case (head[6:0])
      7'b0110011: fmt_raw = 3'd0;
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0001111: fmt_raw = 3'd1;
      7'b0100011: fmt_raw = 3'd2;
      7'b1100011: fmt_raw = 3'd3;
      7'b0110111, 7'b0010111: fmt_raw = 3'd4;
      7'b1101111: fmt_raw = 3'd5;
      default:    fmt_raw = 3'd7;
    endcase
  end

  // Immediate reassembly. B and J scatter their bits across the word and
  // have an implied zero LSB.
  always_comb begin
    imm_raw = '0;
    case (fmt_raw)
      3'd1: imm_raw = {{20{head[31]}}, head[31:20]};
      3'd2: imm_raw = {{20{head[31]}}, head[31:25], head[11:7]};
      3'd3: imm_raw = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
      3'd4: imm_raw = {head[31:12], 12'b0};
      3'd5: imm_raw = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
      default: imm_raw = '0;
    endcase
  end

  // Decoded outputs are zeroed while empty, so stale storage never leaks out.
  always_comb begin
    out_pc = '0;
    opcode = '0;
    rd     = '0;
    funct3 = '0;
    rs1    = '0;
    rs2    = '0;
    funct7 = '0;
    imm    = '0;
    fmt    = '0;
    if (out_valid) begin
      out_pc = pc_mem[rd_ptr];
      opcode = head[6:0];
      rd     = head[11:7];
      funct3 = head[14:12];
      rs1    = head[19:15];
      rs2    = head[24:20];
      funct7 = head[31:25];
      imm    = imm_raw;
      fmt    = fmt_raw;
    end
  end

`ifdef RV32I_DECQ_ILLEGAL_EN
  // R-type accepts only the two funct7 values used by base RV32I.
  assign illegal = out_valid &&
                   (fmt_raw == 3'd7 || head[1:0] != 2'b11 ||
                    (fmt_raw == 3'd0 && head[31:25] != 7'b0000000 &&
                     head[31:25] != 7'b0100000));
`endif

endmodule
